// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: PC feedback, redirect, instruction-memory request/
// response and the decoder-facing instruction buffer.
//   master : the fetch unit (drives next_pc, imem request, buffered instr, fault)
//   slave  : the surroundings (PC register, memory, decoder, branch unit)
interface instr_fetch_unit_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic [ADDR_W-1:0]  pc_in;
   logic [ADDR_W-1:0]  next_pc;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               imem_req_valid;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_req_ready;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr_data;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_ready;
   logic               fetch_fault;

   modport master (
      input  pc_in, redirect_valid, redirect_pc, imem_req_ready,
             imem_rsp_valid, imem_rsp_data, instr_ready,
      output next_pc, imem_req_valid, imem_req_addr, instr_valid,
             instr_data, instr_pc, fetch_fault
   );

   modport slave (
      output pc_in, redirect_valid, redirect_pc, imem_req_ready,
             imem_rsp_valid, imem_rsp_data, instr_ready,
      input  next_pc, imem_req_valid, imem_req_addr, instr_valid,
             instr_data, instr_pc, fetch_fault
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the current PC, issues one instruction-memory
// request at a time, buffers one fetched instruction for decode and feeds
// next_pc back to the PC register. Handles redirects and discards responses
// belonging to requests made stale by a redirect.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high
//   bus    instr_fetch_unit_if.master (pc_in/next_pc, redirect, imem req/rsp,
//          instr buffer, fetch_fault)
//
// Build option: FETCH_MISALIGN_TRAP_EN -- when defined, a fetch from a PC with
// non-zero low bits raises fetch_fault and parks in FAULT until a redirect.
// Otherwise the request address low bits are forced to zero and fetch_fault
// is tied low.
module instr_fetch_unit #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32,
   parameter int PC_STEP = 4
) (
   input  logic               clk,
   input  logic               reset,
   instr_fetch_unit_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} state_t;

   state_t             state;
   logic               req_valid_q;
   logic               instr_valid_q;
   logic [INSTR_W-1:0] instr_data_q;
   logic [ADDR_W-1:0]  instr_pc_q;
   logic [ADDR_W-1:0]  req_pc;
   logic               drop;
   logic               misaligned;
   logic               handshake;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;
   assign misaligned        = (bus.pc_in[1:0] != 2'b00);
   assign bus.imem_req_addr = bus.pc_in;
   assign bus.fetch_fault   = fault_q;
`else
   assign misaligned        = 1'b0;
   assign bus.imem_req_addr = {bus.pc_in[ADDR_W-1:2], 2'b00};
   assign bus.fetch_fault   = 1'b0;
`endif

   // Request valid is a flop set on entry to REQ; a misaligned PC (trap build
   // only) suppresses it because pc_in can change under a pending request.
   assign bus.imem_req_valid = req_valid_q & ~misaligned;
   assign handshake          = (state == REQ) & bus.imem_req_valid & bus.imem_req_ready;

   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_data  = instr_data_q;
   assign bus.instr_pc    = instr_pc_q;

   // Redirect overrides everything outside IDLE; otherwise the PC only moves
   // when a request is accepted.
   always_comb begin
      bus.next_pc = bus.pc_in;
      if (state != IDLE && bus.redirect_valid)
         bus.next_pc = bus.redirect_pc;
      else if (handshake)
         bus.next_pc = bus.pc_in + ADDR_W'(PC_STEP);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         req_valid_q   <= 1'b0;
         instr_valid_q <= 1'b0;
         instr_data_q  <= '0;
         instr_pc_q    <= '0;
         req_pc        <= '0;
         drop          <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
         fault_q       <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state       <= REQ;
               req_valid_q <= 1'b1;
            end
            REQ: begin
               if (handshake) begin
                  // A redirect in the accept cycle makes this request stale.
                  req_pc      <= bus.pc_in;
                  drop        <= bus.redirect_valid;
                  req_valid_q <= 1'b0;
                  state       <= WAIT;
               end
`ifdef FETCH_MISALIGN_TRAP_EN
               else if (misaligned && !bus.redirect_valid) begin
                  fault_q     <= 1'b1;
                  req_valid_q <= 1'b0;
                  state       <= FAULT;
               end
`endif
            end
            WAIT: begin
               if (bus.imem_rsp_valid) begin
                  // A response arriving with a redirect is already stale;
                  // discarding it here avoids waiting for a response that
                  // will never come.
                  if (drop || bus.redirect_valid) begin
                     drop        <= 1'b0;
                     req_valid_q <= 1'b1;
                     state       <= REQ;
                  end else begin
                     instr_data_q  <= bus.imem_rsp_data;
                     instr_pc_q    <= req_pc;
                     instr_valid_q <= 1'b1;
                     state         <= HOLD;
                  end
               end else if (bus.redirect_valid) begin
                  drop <= 1'b1;
               end
            end
            HOLD: begin
               if (bus.redirect_valid || bus.instr_ready) begin
                  instr_valid_q <= 1'b0;
                  req_valid_q   <= 1'b1;
                  state         <= REQ;
               end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
               if (bus.redirect_valid) begin
                  fault_q     <= 1'b0;
                  req_valid_q <= 1'b1;
                  state       <= REQ;
               end
            end
`endif
            default: begin
               state       <= IDLE;
               req_valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

   instr_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .PC_STEP(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef FETCH_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   int n_chk = 0;
   int n_pass = 0;

   // Reference model: what the fetch unit owes its surroundings, kept as
   // "has it started", "is a request in flight (and is it stale)",
   // "is an instruction buffered", "is it faulted".
   bit          m_started;
   bit          m_pend;
   bit          m_pend_drop;
   logic [31:0] m_pend_pc;
   bit          m_buf_v;
   logic [31:0] m_buf_d, m_buf_pc;
   bit          m_fault;

   // DUT values sampled in the last cycle, for literal checks.
   logic        s_req_v, s_iv, s_fault;
   logic [31:0] s_addr, s_next, s_id, s_ipc;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
   endtask

   task automatic model_clear();
      m_started = 0; m_pend = 0; m_pend_drop = 0; m_pend_pc = '0;
      m_buf_v = 0; m_buf_d = '0; m_buf_pc = '0; m_fault = 0;
   endtask

   // One clock cycle: drive inputs, compare every output against the model,
   // advance the model, then let the PC register follow next_pc.
   task automatic cycle(input bit rv, input logic [31:0] rpc, input bit rdy,
                        input bit rsv, input logic [31:0] rsd, input bit ir);
      logic [31:0] pc, e_next, e_addr;
      bit          requesting, mis, e_req_v, hs;
      bus.redirect_valid = rv;  bus.redirect_pc    = rpc;
      bus.imem_req_ready = rdy; bus.imem_rsp_valid = rsv;
      bus.imem_rsp_data  = rsd; bus.instr_ready    = ir;
      pc = bus.pc_in;
      #2;
      requesting = m_started && !m_pend && !m_buf_v && !m_fault;
      mis        = TRAP && (pc[1:0] != 2'b00);
      e_req_v    = requesting && !mis;
      e_addr     = TRAP ? pc : (pc & 32'hFFFF_FFFC);
      hs         = e_req_v && rdy;
      e_next     = (m_started && rv) ? rpc : (hs ? pc + 32'd4 : pc);

      s_req_v = bus.imem_req_valid; s_addr = bus.imem_req_addr; s_next = bus.next_pc;
      s_iv = bus.instr_valid; s_id = bus.instr_data; s_ipc = bus.instr_pc;
      s_fault = bus.fetch_fault;

      chk("imem_req_valid", {31'b0, s_req_v}, {31'b0, e_req_v});
      chk("next_pc", s_next, e_next);
      chk("instr_valid", {31'b0, s_iv}, {31'b0, m_buf_v});
      chk("fetch_fault", {31'b0, s_fault}, {31'b0, m_fault});
      if (e_req_v) chk("imem_req_addr", s_addr, e_addr);
      if (m_buf_v) begin
         chk("instr_data", s_id, m_buf_d);
         chk("instr_pc", s_ipc, m_buf_pc);
      end

      if (!m_started) m_started = 1;
      else if (m_fault) begin
         if (rv) m_fault = 0;
      end else if (m_buf_v) begin
         if (rv || ir) m_buf_v = 0;
      end else if (m_pend) begin
         if (rsv) begin
            if (!m_pend_drop && !rv) begin
               m_buf_v = 1; m_buf_d = rsd; m_buf_pc = m_pend_pc;
            end
            m_pend = 0; m_pend_drop = 0;
         end else if (rv) m_pend_drop = 1;
      end else begin
         if (hs) begin m_pend = 1; m_pend_pc = pc; m_pend_drop = rv; end
         else if (mis && !rv) m_fault = 1;
      end

      @(posedge clk); #1;
      bus.pc_in = e_next;
   endtask

   task automatic zeros_in_reset(input string tag);
      chk({tag, ".req_valid"}, {31'b0, bus.imem_req_valid}, 32'd0);
      chk({tag, ".instr_valid"}, {31'b0, bus.instr_valid}, 32'd0);
      chk({tag, ".fetch_fault"}, {31'b0, bus.fetch_fault}, 32'd0);
      chk({tag, ".instr_data"}, bus.instr_data, 32'd0);
      chk({tag, ".instr_pc"}, bus.instr_pc, 32'd0);
   endtask

   task automatic do_reset(input bit rsp);
      reset = 1'b1;
      bus.imem_rsp_valid = rsp; bus.imem_rsp_data = $urandom;
      bus.redirect_valid = 1'b0; bus.instr_ready = 1'b0;
      #2;
      zeros_in_reset("rst_async");
      @(posedge clk); #1;
      zeros_in_reset("rst_held");
      reset = 1'b0;
      model_clear();
   endtask

   initial begin
      bus.pc_in = '0; bus.redirect_valid = 0; bus.redirect_pc = '0;
      bus.imem_req_ready = 0; bus.imem_rsp_valid = 0; bus.imem_rsp_data = '0;
      bus.instr_ready = 0;
      model_clear();
      #1;
      do_reset(1'b0);

      // Fetch of 0x0, response one cycle later, held until consumed.
      cycle(0, 0, 1, 0, 0, 0);                        // IDLE
      chk("lit.idle_req_valid", {31'b0, s_req_v}, 32'd0);
      cycle(0, 0, 1, 0, 0, 0);                        // REQ accepted
      chk("lit.req_valid", {31'b0, s_req_v}, 32'd1);
      chk("lit.req_addr0", s_addr, 32'h0);
      chk("lit.next_pc4", s_next, 32'h4);
      cycle(0, 0, 1, 1, 32'h0050_0093, 0);            // WAIT, response
      cycle(0, 0, 1, 0, 0, 0);                        // HOLD
      chk("lit.instr_valid", {31'b0, s_iv}, 32'd1);
      chk("lit.instr_data", s_id, 32'h0050_0093);
      chk("lit.instr_pc", s_ipc, 32'h0);
      cycle(0, 0, 1, 0, 0, 0);                        // HOLD, not consumed
      chk("lit.hold_no_req", {31'b0, s_req_v}, 32'd0);
      chk("lit.hold_data", s_id, 32'h0050_0093);
      cycle(0, 0, 1, 0, 0, 1);                        // consumed
      cycle(0, 0, 1, 0, 0, 0);                        // REQ at 0x4
      chk("lit.req_addr4", s_addr, 32'h4);
      chk("lit.next_pc8", s_next, 32'h8);
      // Redirect while waiting: response dropped, refetch at 0x100.
      cycle(1, 32'h100, 0, 0, 0, 0);
      chk("lit.redirect_next", s_next, 32'h100);
      cycle(0, 0, 0, 1, 32'hDEAD_BEEF, 0);            // stale response
      cycle(0, 0, 0, 0, 0, 0);
      chk("lit.dropped", {31'b0, s_iv}, 32'd0);
      chk("lit.req_addr100", s_addr, 32'h100);
      // PC wrap.
      cycle(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      chk("lit.wrap_addr", s_addr, 32'hFFFF_FFFC);
      chk("lit.wrap_next", s_next, 32'h0);
      // Reset while waiting, with a response arriving during reset.
      do_reset(1'b1);
      cycle(0, 0, 0, 1, 32'h1234_5678, 0);
      chk("lit.post_rst_iv", {31'b0, s_iv}, 32'd0);
      cycle(0, 0, 0, 1, 32'h1234_5678, 0);
      chk("lit.post_rst_iv2", {31'b0, s_iv}, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
      cycle(1, 32'h2, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 0, 0);
      chk("lit.mis_no_req", {31'b0, s_req_v}, 32'd0);
      cycle(0, 0, 1, 0, 0, 0);
      chk("lit.fault", {31'b0, s_fault}, 32'd1);
      chk("lit.fault_hold_pc", s_next, 32'h2);
      cycle(1, 32'h8, 1, 0, 0, 0);
      chk("lit.fault_redirect", s_next, 32'h8);
      cycle(0, 0, 0, 0, 0, 0);
      chk("lit.fault_clear", {31'b0, s_fault}, 32'd0);
      chk("lit.fault_req_addr", s_addr, 32'h8);
`endif

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         logic [31:0] rpc;
         if ($urandom_range(0, 599) == 0) begin
            do_reset($urandom_range(0, 1) == 1);
         end else begin
            rpc = $urandom;
            if ($urandom_range(0, 15) != 0) rpc = rpc & 32'hFFFF_FFFC;
            cycle($urandom_range(0, 7) == 0, rpc, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) < 2, $urandom, $urandom_range(0, 1) == 1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
